// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared symbol codes, capture FSM states and helpers for the Genius game
package genius_pkg;

    localparam logic [1:0] SYM_BTN0 = 2'b00;
    localparam logic [1:0] SYM_BTN1 = 2'b01;
    localparam logic [1:0] SYM_BTN2 = 2'b10;
    localparam logic [1:0] SYM_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        WAIT_PRESS = 2'b01,
        OUTPUT     = 2'b10,
        RELEASE    = 2'b11
    } capture_state_t;

    function automatic logic [1:0] encode_button(input logic [2:0] onehot);
        logic [1:0] code;
        case (onehot)
            3'b001:  code = SYM_BTN0;
            3'b010:  code = SYM_BTN1;
            3'b100:  code = SYM_BTN2;
            default: code = SYM_NONE;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] count_high(input logic [2:0] levels);
        return 2'(levels[0]) + 2'(levels[1]) + 2'(levels[2]);
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// rtl/debounce_botao.sv - two-flop synchroniser, debounce counter, stable level and rise pulse for one button
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_dly_q;
    logic [CW-1:0] cnt_q;

    // The stable level only flips after the synchronised input has disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw_i;
            sync2_q      <= sync1_q;
            stable_dly_q <= stable_q;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = stable_q & ~stable_dly_q;

endmodule

// File: rtl/captura_botoes.sv
// rtl/captura_botoes.sv - armed single-press capture of three buttons with valid/ready result handoff
module captura_botoes #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       btn0,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       arm,
    output logic       result_valid,
    input  logic       result_ready,
    output logic [1:0] symbol,
    output logic       timeout,
    output logic       multi_press,
    output logic       busy
);

    import genius_pkg::*;

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]     raw;
    logic [2:0]     stable;
    logic [2:0]     rise;
    logic [1:0]     n_high;

    capture_state_t state_q;
    logic [TW-1:0]  timer_q;
    logic           valid_q;
    logic [1:0]     symbol_q;
    logic           timeout_q;
    logic           multi_q;
    logic           busy_q;

    assign raw    = {btn2, btn1, btn0};
    assign n_high = count_high(stable);

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
        .clock    (clock),
        .rst_n    (rst_n),
        .raw_i    (raw[0]),
        .stable_o (stable[0]),
        .rise_o   (rise[0])
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clock    (clock),
        .rst_n    (rst_n),
        .raw_i    (raw[1]),
        .stable_o (stable[1]),
        .rise_o   (rise[1])
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clock    (clock),
        .rst_n    (rst_n),
        .raw_i    (raw[2]),
        .stable_o (stable[2]),
        .rise_o   (rise[2])
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            valid_q   <= 1'b0;
            symbol_q  <= SYM_BTN0;
            timeout_q <= 1'b0;
            multi_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_q <= WAIT_PRESS;
                        timer_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    // A press seen in the last timer cycle still wins over the timeout.
                    if (|rise) begin
                        state_q   <= OUTPUT;
                        valid_q   <= 1'b1;
                        timeout_q <= 1'b0;
                        if (n_high >= 2'd2) begin
                            symbol_q <= SYM_NONE;
                            multi_q  <= 1'b1;
                        end else begin
                            symbol_q <= encode_button(rise);
                            multi_q  <= 1'b0;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        state_q   <= OUTPUT;
                        valid_q   <= 1'b1;
                        symbol_q  <= SYM_NONE;
                        timeout_q <= 1'b1;
                        multi_q   <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                OUTPUT: begin
                    if (result_ready) begin
                        state_q <= RELEASE;
                        valid_q <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (stable == 3'b000) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result_valid = valid_q;
    assign symbol       = symbol_q;
    assign timeout      = timeout_q;
    assign multi_press  = multi_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_captura_botoes.sv
// tb/tb_captura_botoes.sv - self-checking bench for captura_botoes
module tb_captura_botoes;

    import genius_pkg::*;

    localparam int DEB = 4;
    localparam int TO  = 32;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       btn0, btn1, btn2;
    logic       arm;
    logic       result_ready;
    logic       result_valid;
    logic [1:0] symbol;
    logic       timeout;
    logic       multi_press;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] sym;
        logic       to;
        logic       mp;
    } exp_t;

    typedef struct {
        logic [2:0] pre;
        logic [2:0] press;
        logic [1:0] sym;
        logic       to;
        logic       mp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    captura_botoes #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .btn0         (btn0),
        .btn1         (btn1),
        .btn2         (btn2),
        .arm          (arm),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .symbol       (symbol),
        .timeout      (timeout),
        .multi_press  (multi_press),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: pop one expected result per accepted handshake.
    always @(negedge clock) begin
        exp_t e;
        if (rst_n && result_valid && result_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_result", 32'(1), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("sb_result", 32'({symbol, timeout, multi_press}), 32'({e.sym, e.to, e.mp}));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_btn(input logic [2:0] m);
        {btn2, btn1, btn0} = m;
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (n < bound && !result_valid) begin
            @(posedge clock);
            @(negedge clock);
            n++;
        end
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (n < bound && busy) begin
            @(posedge clock);
            @(negedge clock);
            n++;
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick(1);
        result_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        set_btn(v.pre);
        tick(12);
        do_arm();
        sb_q.push_back('{v.sym, v.to, v.mp});
        set_btn(v.pre | v.press);
        wait_valid(TO + 20, n);
        check("vec_valid_seen", 32'(result_valid), 32'(1));
        accept();
        @(negedge clock);
        check("vec_valid_drop", 32'(result_valid), 32'(0));
        set_btn(3'b000);
        wait_idle(30, n);
        check("vec_back_idle", 32'(busy), 32'(0));
        tick(2);
    endtask

    initial begin
        int n;
        vecs[0] = '{3'b000, 3'b001, SYM_BTN0, 1'b0, 1'b0};
        vecs[1] = '{3'b000, 3'b010, SYM_BTN1, 1'b0, 1'b0};
        vecs[2] = '{3'b000, 3'b100, SYM_BTN2, 1'b0, 1'b0};
        vecs[3] = '{3'b000, 3'b101, SYM_NONE, 1'b0, 1'b1};
        vecs[4] = '{3'b000, 3'b111, SYM_NONE, 1'b0, 1'b1};
        vecs[5] = '{3'b000, 3'b011, SYM_NONE, 1'b0, 1'b1};
        vecs[6] = '{3'b001, 3'b010, SYM_NONE, 1'b0, 1'b1};
        vecs[7] = '{3'b001, 3'b000, SYM_NONE, 1'b1, 1'b0};
        vecs[8] = '{3'b100, 3'b000, SYM_NONE, 1'b1, 1'b0};
        vecs[9] = '{3'b000, 3'b000, SYM_NONE, 1'b1, 1'b0};

        rst_n = 1'b0;
        set_btn(3'b000);
        arm = 1'b0;
        result_ready = 1'b0;
        tick(3);
        check("reset_outputs", 32'({result_valid, symbol, timeout, multi_press, busy}), 32'(0));
        rst_n = 1'b1;
        tick(2);

        // btn1 held 10 cycles: latency, late ready, release timing
        do_arm();
        check("busy_after_arm", 32'(busy), 32'(1));
        sb_q.push_back('{SYM_BTN1, 1'b0, 1'b0});
        btn1 = 1'b1;
        wait_valid(20, n);
        check("btn1_latency", 32'(n), 32'(7));
        tick(2);
        check("btn1_hold_before_ready", 32'({result_valid, symbol, timeout, multi_press}), 32'({1'b1, SYM_BTN1, 1'b0, 1'b0}));
        accept();
        btn1 = 1'b0;
        @(negedge clock);
        check("btn1_valid_drop", 32'(result_valid), 32'(0));
        wait_idle(20, n);
        check("btn1_release_busy", 32'(n >= 6 && n <= 7), 32'(1));
        tick(2);

        // short btn2 glitch ignored, then timeout
        do_arm();
        btn2 = 1'b1;
        tick(3);
        btn2 = 1'b0;
        sb_q.push_back('{SYM_NONE, 1'b1, 1'b0});
        wait_valid(60, n);
        check("timeout_latency", 32'(n + 3), 32'(TO));
        accept();
        wait_idle(20, n);
        check("timeout_back_idle", 32'(busy), 32'(0));
        tick(2);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // btn2 result held with ready low; extra presses during OUTPUT ignored
        do_arm();
        sb_q.push_back('{SYM_BTN2, 1'b0, 1'b0});
        btn2 = 1'b1;
        wait_valid(20, n);
        check("hold_valid_seen", 32'(result_valid), 32'(1));
        for (int i = 0; i < 20; i++) begin
            btn0 = (i >= 5 && i < 15);
            @(posedge clock);
            @(negedge clock);
            check("hold_stable", 32'({result_valid, symbol, timeout, multi_press}), 32'({1'b1, SYM_BTN2, 1'b0, 1'b0}));
        end
        accept();
        set_btn(3'b000);
        wait_idle(30, n);
        check("hold_back_idle", 32'(busy), 32'(0));
        btn1 = 1'b1;
        tick(12);
        btn1 = 1'b0;
        tick(12);
        check("idle_press_ignored", 32'({result_valid, busy}), 32'(0));

        // reset during WAIT_PRESS
        do_arm();
        btn0 = 1'b1;
        tick(3);
        #3 rst_n = 1'b0;
        #1 check("reset_in_wait", 32'({result_valid, symbol, timeout, multi_press, busy}), 32'(0));
        set_btn(3'b000);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // reset during OUTPUT
        do_arm();
        btn1 = 1'b1;
        wait_valid(20, n);
        check("pre_reset_output_valid", 32'(result_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1 check("reset_in_output", 32'({result_valid, symbol, timeout, multi_press, busy}), 32'(0));
        set_btn(3'b000);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        run_vec('{3'b000, 3'b001, SYM_BTN0, 1'b0, 1'b0});

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
